// File: rtl/lockout_pkg.sv
// Shared types and width helpers for the lockout controller.
package lockout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int unsigned DEF_MAX_TRY    = 3;
    localparam int unsigned DEF_UNLOCK_CYC = 50000000;
    localparam int unsigned DEF_LOCK_CYC   = 500000000;
    localparam int unsigned DEF_BLINK_CYC  = 12500000;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lockout_ctrl_cyc_timer.sv
// Loadable down-counter shared by the door window and the lockout period.
module cyc_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lockout_ctrl.sv
// Door/alarm controller driven by the lock core's pass/fail verdicts;
// locks the keypad out after MAX_TRY consecutive failures.
module lockout_ctrl
    import lockout_pkg::*;
#(
    parameter int unsigned MAX_TRY    = DEF_MAX_TRY,
    parameter int unsigned UNLOCK_CYC = DEF_UNLOCK_CYC,
    parameter int unsigned LOCK_CYC   = DEF_LOCK_CYC,
    parameter int unsigned BLINK_CYC  = DEF_BLINK_CYC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pass,
    input  logic                         fail,
    output logic                         door_open,
    output logic                         locked,
    output logic                         alarm_led,
    output logic [$clog2(MAX_TRY+1)-1:0] tries_left
);

    localparam int unsigned TW = width_of(max_u(UNLOCK_CYC, LOCK_CYC));
    localparam int unsigned BW = width_of(BLINK_CYC);
    localparam int unsigned CW = $clog2(MAX_TRY + 1);

    localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYC - 1);
    localparam logic [CW-1:0] TRY_MAX     = CW'(MAX_TRY);

    lock_state_t   state;
    logic [1:0]    pass_sync;
    logic [1:0]    fail_sync;
    logic          pass_d;
    logic          fail_d;
    logic          pass_evt;
    logic          fail_evt;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_done;
    logic [BW-1:0] blink_cnt;

    // Verdicts come from the button clock domain: two-flop synchronise, then edge-detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_sync <= '0;
            fail_sync <= '0;
            pass_d    <= 1'b0;
            fail_d    <= 1'b0;
        end else begin
            pass_sync <= {pass_sync[0], pass};
            fail_sync <= {fail_sync[0], fail};
            pass_d    <= pass_sync[1];
            fail_d    <= fail_sync[1];
        end
    end

    assign pass_evt = pass_sync[1] & ~pass_d;
    assign fail_evt = fail_sync[1] & ~fail_d;

    // Timer reloads happen in the same cycle the FSM commits to the new state.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            IDLE: begin
                if (fail_evt) begin
                    if (tries_left <= CW'(1)) begin
                        timer_load = 1'b1;
                        timer_val  = LOCK_LOAD;
                    end
                end else if (pass_evt) begin
                    timer_load = 1'b1;
                    timer_val  = UNLOCK_LOAD;
                end
            end
            OPEN: begin
                if (pass_evt) begin
                    timer_load = 1'b1;
                    timer_val  = UNLOCK_LOAD;
                end
            end
            default: ;
        endcase
    end

    cyc_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            door_open  <= 1'b0;
            locked     <= 1'b0;
            alarm_led  <= 1'b0;
            tries_left <= TRY_MAX;
            blink_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous pass is dropped: a fail always wins.
                    if (fail_evt) begin
                        if (tries_left <= CW'(1)) begin
                            state      <= LOCKED;
                            locked     <= 1'b1;
                            alarm_led  <= 1'b1;
                            blink_cnt  <= '0;
                            tries_left <= '0;
                        end else begin
                            tries_left <= tries_left - CW'(1);
                        end
                    end else if (pass_evt) begin
                        state      <= OPEN;
                        door_open  <= 1'b1;
                        tries_left <= TRY_MAX;
                    end
                end
                OPEN: begin
                    if (!pass_evt && timer_done) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (timer_done) begin
                        state      <= IDLE;
                        locked     <= 1'b0;
                        alarm_led  <= 1'b0;
                        tries_left <= TRY_MAX;
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        alarm_led <= ~alarm_led;
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    door_open <= 1'b0;
                    locked    <= 1'b0;
                    alarm_led <= 1'b0;
                end
            endcase
        end
    end

endmodule
